// File: rtl/mole_round_scheduler.sv
// Whac-a-mole round sequencer: draws a random mole, times the hit window,
// tracks lives and flags game over on behalf of the game FSM.
module mole_round_scheduler #(
    parameter int unsigned TICK_DIV  = 50000,
    parameter int unsigned NUM_MOLES = 18,
    parameter int unsigned LIVES     = 3,
    parameter int unsigned WIN_L1    = 1000,
    parameter int unsigned WIN_L2    = 700,
    parameter int unsigned WIN_L3    = 400
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           level,
    input  logic                 abort,
    input  logic                 ready_for_mole,
    input  logic                 timeout_start,
    output logic [NUM_MOLES-1:0] led_number,
    output logic                 timeout,
    output logic [1:0]           lives,
    output logic                 game_over
);

    localparam int unsigned LFSR_W = 16;
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned REM_W  = 10;
    localparam int unsigned PRE_W  = $clog2(TICK_DIV + 1);

    localparam logic [LFSR_W-1:0]    LFSR_SEED  = 16'hACE1;
    localparam logic [IDX_W-1:0]     NO_IDX     = '1;
    localparam logic [PRE_W-1:0]     PRESC_MAX  = PRE_W'(TICK_DIV - 1);
    localparam logic [NUM_MOLES-1:0] LED_ONE    = NUM_MOLES'(1);
    localparam logic [1:0]           LIVES_INIT = 2'(LIVES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_REQ,
        S_DRAW,
        S_RUN,
        S_EXPIRE,
        S_OVER
    } state_t;

    state_t                 state_q,      state_d;
    logic [LFSR_W-1:0]      lfsr_q,       lfsr_d;
    logic [IDX_W-1:0]       last_idx_q,   last_idx_d;
    logic [REM_W-1:0]       remaining_q,  remaining_d;
    logic [PRE_W-1:0]       presc_q,      presc_d;
    logic                   seen_start_q, seen_start_d;
    logic [1:0]             level_q,      level_d;
    logic [NUM_MOLES-1:0]   led_q,        led_d;
    logic                   timeout_q,    timeout_d;
    logic [1:0]             lives_q,      lives_d;
    logic                   game_over_q,  game_over_d;

    logic [IDX_W-1:0]       cand_idx;
    logic                   cand_ok;
    logic                   start_ok;
    logic [REM_W-1:0]       win_load;

    // Candidate mole and window length for the latched level
    always_comb begin
        cand_idx = lfsr_q[IDX_W-1:0];
        cand_ok  = (32'(cand_idx) < NUM_MOLES) && (cand_idx != last_idx_q);
        start_ok = start && (level != 2'd0);
        case (level_q)
            2'd1:    win_load = REM_W'(WIN_L1);
            2'd2:    win_load = REM_W'(WIN_L2);
            default: win_load = REM_W'(WIN_L3);
        endcase
    end

    // State register and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            lfsr_q       <= LFSR_SEED;
            last_idx_q   <= NO_IDX;
            remaining_q  <= '0;
            presc_q      <= '0;
            seen_start_q <= 1'b0;
            level_q      <= 2'd0;
            led_q        <= '0;
            timeout_q    <= 1'b1;
            lives_q      <= 2'd0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            last_idx_q   <= last_idx_d;
            remaining_q  <= remaining_d;
            presc_q      <= presc_d;
            seen_start_q <= seen_start_d;
            level_q      <= level_d;
            led_q        <= led_d;
            timeout_q    <= timeout_d;
            lives_q      <= lives_d;
            game_over_q  <= game_over_d;
        end
    end

    // Next-state and next-output logic; abort overrides everything
    always_comb begin
        state_d      = state_q;
        lfsr_d       = {lfsr_q[LFSR_W-2:0],
                        lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        last_idx_d   = last_idx_q;
        remaining_d  = remaining_q;
        presc_d      = presc_q;
        seen_start_d = seen_start_q;
        level_d      = level_q;
        led_d        = led_q;
        timeout_d    = timeout_q;
        lives_d      = lives_q;
        game_over_d  = game_over_q;

        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    level_d     = level;
                    lives_d     = LIVES_INIT;
                    game_over_d = 1'b0;
                    state_d     = S_WAIT_REQ;
                end
            end

            S_WAIT_REQ: begin
                led_d = '0;
                if (ready_for_mole) begin
                    state_d = S_DRAW;
                end
            end

            S_DRAW: begin
                if (cand_ok) begin
                    led_d        = LED_ONE << cand_idx;
                    last_idx_d   = cand_idx;
                    remaining_d  = win_load;
                    presc_d      = '0;
                    seen_start_d = 1'b0;
                    state_d      = S_RUN;
                end
            end

            S_RUN: begin
                if (timeout_start) begin
                    seen_start_d = 1'b1;
                    if (presc_q == PRESC_MAX) begin
                        presc_d     = '0;
                        remaining_d = remaining_q - REM_W'(1);
                        if (remaining_q == REM_W'(1)) begin
                            timeout_d = 1'b0;
                            led_d     = '0;
                            state_d   = S_EXPIRE;
                        end
                    end else begin
                        presc_d = presc_q + PRE_W'(1);
                    end
                end else if (seen_start_q) begin
                    led_d   = '0;
                    state_d = S_WAIT_REQ;
                end
            end

            S_EXPIRE: begin
                timeout_d = 1'b0;
                led_d     = '0;
                if (!timeout_start) begin
                    timeout_d = 1'b1;
                    lives_d   = lives_q - 2'd1;
                    if (lives_q == 2'd1) begin
                        game_over_d = 1'b1;
                        state_d     = S_OVER;
                    end else begin
                        state_d = S_WAIT_REQ;
                    end
                end
            end

            S_OVER: begin
                game_over_d = 1'b1;
                led_d       = '0;
                if (start_ok) begin
                    level_d     = level;
                    lives_d     = LIVES_INIT;
                    game_over_d = 1'b0;
                    state_d     = S_WAIT_REQ;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort) begin
            state_d     = S_IDLE;
            led_d       = '0;
            lives_d     = 2'd0;
            timeout_d   = 1'b1;
            game_over_d = 1'b0;
        end
    end

    assign led_number = led_q;
    assign timeout    = timeout_q;
    assign lives      = lives_q;
    assign game_over  = game_over_q;

endmodule

// File: doc/mole_round_scheduler.md
# mole_round_scheduler

- Sequences each whac-a-mole round on behalf of the game FSM.
- On each `ready_for_mole` request it draws a pseudo-random mole and drives it one-hot on `led_number`.
- It times the hit window for the selected level and drives the `timeout` input that the FSM consumes.
- It tracks remaining lives and flags game over.
- It sits between the key/level decode, the game FSM and the LED driver.

## Interface

Parameters:
- `TICK_DIV`, default 50000: clock cycles per 1 ms tick (50 MHz).
- `NUM_MOLES`, default 18: number of mole LEDs; legal range 2..32.
- `LIVES`, default 3: lives at game start; legal range 1..3.
- `WIN_L1`, default 1000: level-1 window in ms.
- `WIN_L2`, default 700: level-2 window in ms.
- `WIN_L3`, default 400: level-3 window in ms.

Ports:
- `clk` in 1: system clock. One clock domain only.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: single-cycle pulse to begin a game.
- `level` in 2: selected level, sampled on `start`. Value 0 is invalid.
- `abort` in 1: single-cycle pulse to return to IDLE from any state.
- `ready_for_mole` in 1: FSM request for a new mole.
- `timeout_start` in 1: high while the FSM waits for a hit.
- `led_number` out NUM_MOLES: one-hot active mole; 0 when no mole.
- `timeout` out 1: 1 = time remaining; 0 = window expired.
- `lives` out 2: lives remaining.
- `game_over` out 1: high in OVER.

## Operation

- States: IDLE, WAIT_REQ, DRAW, RUN, EXPIRE, OVER.
- Reset values: state IDLE, `led_number`=0, `timeout`=1, `lives`=0, `game_over`=0, LFSR=16'hACE1, `last_idx`=all ones (no previous mole).
- The LFSR is a 16-bit maximal-length Fibonacci LFSR with taps 16,14,13,11. It advances every cycle in every state.
- IDLE:
  - `start` with `level`≠0: latch level, set `lives`=LIVES, go to WAIT_REQ.
  - `start` with `level`=0: ignored.
- WAIT_REQ:
  - `led_number`=0.
  - `ready_for_mole`: go to DRAW.
- DRAW:
  - Candidate index = LFSR[4:0].
  - Accept only if index < NUM_MOLES and index ≠ `last_idx`; otherwise retry next cycle with the advanced LFSR.
  - On accept:
    - set `led_number` = 1<<index and store `last_idx`;
    - load `remaining` (10 bits) with WIN_L1/L2/L3 for the latched level;
    - clear the prescaler and the `seen_start` flag;
    - go to RUN.
- RUN:
  - While `timeout_start`=1: set `seen_start`. The prescaler counts 0..TICK_DIV-1 and wraps; `remaining` decrements on each wrap.
  - Expiry: `remaining`=1 and prescaler=TICK_DIV-1 with `timeout_start`=1 → EXPIRE.
  - Hit: `timeout_start`=0 and `seen_start`=1 → clear `led_number`, go to WAIT_REQ. `lives` is unchanged.
  - `timeout_start`=0 before `seen_start` is set: counting is held.
- EXPIRE:
  - `timeout`=0 and `led_number`=0.
  - Held until `timeout_start`=0.
  - Then `lives` decrements. If the result is 0, go to OVER; else go to WAIT_REQ.
- OVER:
  - `game_over`=1, `led_number`=0.
  - `start` with a valid level: new game, equivalent to the IDLE transition.
- `abort`, from any state: go to IDLE next cycle. Clears `led_number` and `lives`; sets `timeout`=1. `abort` has priority over every other event.

## Timing

- All outputs are registered.
- `led_number` becomes valid on the cycle after DRAW accepts.
- Minimum latency from `ready_for_mole` to `led_number` valid is 2 cycles. Retries add 1 cycle each; worst case is bounded by the LFSR period.
- `timeout` falls exactly WIN_Lx×TICK_DIV counted cycles after the first cycle with `timeout_start`=1.
  - Counted cycles are those with `timeout_start`=1.
  - `timeout` stays 0 until the cycle after `timeout_start` drops.
- Hit and expiry cannot coincide: expiry requires `timeout_start`=1, hit requires 0.
- `ready_for_mole` outside WAIT_REQ is ignored.
- `start` outside IDLE/OVER is ignored.
- `lives` never underflows; decrement occurs only in EXPIRE, where `lives` ≥ 1.
- `rst_n` low mid-round: outputs return to reset values immediately (asynchronous reset).

## Test plan

All scenarios use TICK_DIV=4, WIN_L1=5, WIN_L2=3, WIN_L3=2.

- Reset and no-op:
  - Stimulus: release `rst_n`, apply no `start`.
  - Required: `led_number`=0, `timeout`=1, `lives`=0, `game_over`=0, `ready_for_mole` ignored.
- Mole draw:
  - Stimulus: `start` with `level`=1, then 20 rounds of `ready_for_mole` → hit.
  - Required: every `led_number` is one-hot, index <18, never equal to the previous round's index; `lives` stays 3.
- Timed miss:
  - Stimulus: `level`=3, hold `timeout_start`=1.
  - Required: `timeout` falls exactly 8 counted cycles after the first high `timeout_start`. After `timeout_start` drops, `timeout`=1 and `lives` 3→2.
- Game over:
  - Stimulus: three consecutive misses at `level`=2.
  - Required: `lives`=0, `game_over`=1, `led_number`=0.
  - Then `start` with `level`=1: `lives`=3, `game_over`=0.
- Hit then stall:
  - Stimulus: drop `timeout_start` after 5 counted cycles.
  - Required: `led_number`=0 next cycle, no `timeout` pulse, `lives` unchanged.
  - Also: `timeout_start` low for 10 cycles before first rising (`seen_start` clear) → counting held, no expiry.
- Abort and reset:
  - Stimulus: `abort` during RUN and during EXPIRE; also `rst_n` low mid-RUN.
  - Required: IDLE next cycle (or immediately on reset) with `led_number`=0, `timeout`=1, `lives`=0.
  - `start` with `level`=0 in IDLE → remains IDLE.
